// File: rtl/os_ctrl_pkg.sv
// Shared opcodes, scheduler state and trap-cause encodings for the OS control path.
package os_ctrl_pkg;

  localparam logic [5:0] OP_IN       = 6'h08;
  localparam logic [5:0] OP_JR       = 6'h13;
  localparam logic [5:0] OP_HALT     = 6'h19;
  localparam logic [5:0] OP_SET_PID  = 6'h1C;
  localparam logic [5:0] OP_KSWAP    = 6'h21;
  localparam logic [5:0] OP_BR_05    = 6'h05;
  localparam logic [5:0] OP_BEQ      = 6'h0A;
  localparam logic [5:0] OP_BNE      = 6'h0B;

  typedef enum logic [1:0] {
    ST_KERNEL = 2'd0,
    ST_USER   = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_TRAP   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'b00,
    CAUSE_QUANTUM = 2'b01,
    CAUSE_SYSCALL = 2'b10,
    CAUSE_EXIT    = 2'b11
  } cause_e;

  // Control-flow and IN opcodes must not be the preemption point: the PC
  // they leave behind would not be a clean resume address.
  function automatic logic drain_exempt(input logic [5:0] op);
    return (op == OP_BR_05) || (op == OP_BEQ) || (op == OP_BNE) ||
           (op == OP_JR)    || (op == OP_IN);
  endfunction

endpackage

// File: rtl/quantum_scheduler_if.sv
// Core <-> scheduler signal bundle; master is the core/control unit side.
interface quantum_scheduler_if #(
  parameter int QUANTUM_W = 16,
  parameter int PID_W     = 6
);
  logic                 instr_valid;
  logic [5:0]           opcode;
  logic                 pid_wr;
  logic [PID_W-1:0]     pid_in;
  logic                 quantum_wr;
  logic [QUANTUM_W-1:0] quantum_in;
  logic                 io_ack;
  logic                 stall;
  logic                 trap;
  logic [1:0]           trap_cause;
  logic                 kernel_mode;
  logic [PID_W-1:0]     cur_pid;
  logic [QUANTUM_W-1:0] instr_count;

  modport master (
    output instr_valid, opcode, pid_wr, pid_in, quantum_wr, quantum_in, io_ack,
    input  stall, trap, trap_cause, kernel_mode, cur_pid, instr_count
  );

  modport slave (
    input  instr_valid, opcode, pid_wr, pid_in, quantum_wr, quantum_in, io_ack,
    output stall, trap, trap_cause, kernel_mode, cur_pid, instr_count
  );
endinterface

// File: rtl/quantum_scheduler_counter.sv
// Quantum register plus retired-instruction counter with an "about to hit" compare.
module quantum_counter #(
  parameter int W         = 16,
  parameter int DEFAULT_Q = 100
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_count,
  output logic         o_hit_next
);
  logic [W-1:0] r_count;
  logic [W-1:0] r_quantum;
  logic [W-1:0] w_q_m1;

  // Quantum is never 0, so quantum-1 cannot underflow; comparing against it
  // flags the increment that lands exactly on the quantum.
  assign w_q_m1     = r_quantum - W'(1);
  assign o_hit_next = (r_count == w_q_m1);
  assign o_count    = r_count;

  // Quantum load (0 coerced to 1) and clear-priority counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count   <= '0;
      r_quantum <= W'(DEFAULT_Q);
    end else begin
      if (i_load) r_quantum <= (i_load_val == '0) ? W'(1) : i_load_val;
      if (i_clr)      r_count <= '0;
      else if (i_en)  r_count <= r_count + W'(1);
    end
  end
endmodule

// File: rtl/quantum_scheduler.sv
// Round-robin preemption controller: mode/PID tracking, quantum expiry, traps, IN wait.
module quantum_scheduler
  import os_ctrl_pkg::*;
#(
  parameter int QUANTUM_W       = 16,
  parameter int DEFAULT_QUANTUM = 100,
  parameter int PID_W           = 6
) (
  input logic                clk,
  input logic                rst_n,
  quantum_scheduler_if.slave bus
);
  state_e             r_state;
  cause_e             r_cause;
  logic               r_trap;
  logic               r_kernel_mode;
  logic               r_armed;
  logic               r_io_wait;
  logic [PID_W-1:0]   r_pending_pid;
  logic [PID_W-1:0]   r_cur_pid;
  logic [QUANTUM_W-1:0] w_count;
  logic               w_hit_next;
  logic               w_retire;
  logic               w_kswap;
  logic               w_halt;

  assign w_retire = bus.instr_valid & ~r_io_wait;
  assign w_kswap  = (bus.opcode == OP_KSWAP);
  assign w_halt   = (bus.opcode == OP_HALT);

  quantum_counter #(.W(QUANTUM_W), .DEFAULT_Q(DEFAULT_QUANTUM)) u_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (bus.quantum_wr && (r_state == ST_KERNEL)),
    .i_load_val(bus.quantum_in),
    .i_clr     ((r_state == ST_KERNEL) || (r_state == ST_TRAP)),
    .i_en      (w_retire && (r_state == ST_USER)),
    .o_count   (w_count),
    .o_hit_next(w_hit_next)
  );

  // Scheduler FSM: dispatch, counting, drain to a safe preemption point, trap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_KERNEL;
      r_cause       <= CAUSE_NONE;
      r_trap        <= 1'b0;
      r_kernel_mode <= 1'b1;
      r_armed       <= 1'b0;
      r_pending_pid <= '0;
      r_cur_pid     <= '0;
    end else begin
      r_trap <= 1'b0;
      case (r_state)
        ST_KERNEL: begin
          if (bus.pid_wr && (bus.pid_in != '0)) begin
            r_pending_pid <= bus.pid_in;
            r_armed       <= 1'b1;
          end
          if (w_retire && (bus.opcode == OP_JR) && r_armed) begin
            r_state       <= ST_USER;
            r_cur_pid     <= r_pending_pid;
            r_armed       <= 1'b0;
            r_kernel_mode <= 1'b0;
          end
        end
        ST_USER: begin
          if (w_retire) begin
            if (w_kswap) begin
              r_state <= ST_TRAP; r_trap <= 1'b1; r_cause <= CAUSE_SYSCALL;
            end else if (w_halt) begin
              r_state <= ST_TRAP; r_trap <= 1'b1; r_cause <= CAUSE_EXIT;
            end else if (w_hit_next) begin
              r_state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (w_retire) begin
            if (w_kswap) begin
              r_state <= ST_TRAP; r_trap <= 1'b1; r_cause <= CAUSE_SYSCALL;
            end else if (w_halt) begin
              r_state <= ST_TRAP; r_trap <= 1'b1; r_cause <= CAUSE_EXIT;
            end else if (!drain_exempt(bus.opcode)) begin
              r_state <= ST_TRAP; r_trap <= 1'b1; r_cause <= CAUSE_QUANTUM;
            end
          end
        end
        default: begin
          // Trap cycle: hand control back to the kernel; PID stays for it to read.
          r_state       <= ST_KERNEL;
          r_kernel_mode <= 1'b1;
        end
      endcase
    end
  end

  // IN wait: set by a retiring IN, cleared only by an ack that arrives while waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_io_wait <= 1'b0;
    end else if (w_retire && (bus.opcode == OP_IN)) begin
      r_io_wait <= 1'b1;
    end else if (r_io_wait && bus.io_ack) begin
      r_io_wait <= 1'b0;
    end
  end

  assign bus.stall       = r_io_wait;
  assign bus.trap        = r_trap;
  assign bus.trap_cause  = r_cause;
  assign bus.kernel_mode = r_kernel_mode;
  assign bus.cur_pid     = r_cur_pid;
  assign bus.instr_count = w_count;

endmodule

// File: tb/tb_quantum_scheduler.sv
// Directed bench: trap causes go through a scoreboard queue checked by a trap monitor.
module tb_quantum_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [1:0] exp_q[$];
  logic [1:0] mon_exp;

  always #5 clk = ~clk;

  quantum_scheduler_if #(.QUANTUM_W(16), .PID_W(6)) bus ();

  quantum_scheduler #(.QUANTUM_W(16), .DEFAULT_QUANTUM(100), .PID_W(6)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every trap pulse must match the next queued cause; a stray or stretched pulse finds the queue empty.
  always @(negedge clk) begin
    if (rst_n && bus.trap === 1'b1) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_trap: observed trap=1 cause=%0h expected no trap", bus.trap_cause);
      end
      if (exp_q.size() != 0) begin
        mon_exp = exp_q.pop_front();
        checks++;
        assert (bus.trap_cause === mon_exp) else begin
          errors++;
          $error("FAIL trap_cause_sb: observed %0h expected %0h", bus.trap_cause, mon_exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic retire(input logic [5:0] op, input logic ack = 1'b0);
    bus.instr_valid = 1'b1;
    bus.opcode      = op;
    bus.io_ack      = ack;
    tick();
    bus.instr_valid = 1'b0;
    bus.opcode      = 6'h00;
    bus.io_ack      = 1'b0;
  endtask

  task automatic dispatch(input logic [5:0] pid, input bit ldq = 1'b0, input logic [15:0] q = 16'd0);
    bus.pid_wr     = 1'b1;
    bus.pid_in     = pid;
    bus.quantum_wr = ldq;
    bus.quantum_in = q;
    tick();
    bus.pid_wr     = 1'b0;
    bus.quantum_wr = 1'b0;
    retire(6'h13);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    bus.instr_valid = 1'b0;
    bus.opcode      = 6'h00;
    bus.pid_wr      = 1'b0;
    bus.pid_in      = 6'd0;
    bus.quantum_wr  = 1'b0;
    bus.quantum_in  = 16'd0;
    bus.io_ack      = 1'b0;
    do_reset();

    // Reset state
    chk("rst_kernel_mode", 32'(bus.kernel_mode), 32'd1);
    chk("rst_stall",       32'(bus.stall),       32'd0);
    chk("rst_trap",        32'(bus.trap),        32'd0);
    chk("rst_cause",       32'(bus.trap_cause),  32'd0);
    chk("rst_cur_pid",     32'(bus.cur_pid),     32'd0);
    chk("rst_count",       32'(bus.instr_count), 32'd0);

    // JR without SET_PID stays in kernel
    retire(6'h13);
    chk("jr_unarmed_kmode", 32'(bus.kernel_mode), 32'd1);
    chk("jr_unarmed_pid",   32'(bus.cur_pid),     32'd0);

    // Quantum 4, dispatch PID 3
    dispatch(6'd3, 1'b1, 16'd4);
    chk("dispatch_kmode", 32'(bus.kernel_mode), 32'd0);
    chk("dispatch_pid",   32'(bus.cur_pid),     32'd3);
    chk("dispatch_count", 32'(bus.instr_count), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      retire(6'h00);
      chk($sformatf("q4_count_%0d", i), 32'(bus.instr_count), 32'(i));
      chk($sformatf("q4_notrap_%0d", i), 32'(bus.trap), 32'd0);
    end
    exp_q.push_back(2'b01);
    retire(6'h00);
    chk("q4_trap",       32'(bus.trap),        32'd1);
    chk("q4_cause",      32'(bus.trap_cause),  32'd1);
    chk("q4_trap_kmode", 32'(bus.kernel_mode), 32'd0);
    chk("q4_drain_hold", 32'(bus.instr_count), 32'd4);
    tick();
    chk("q4_after_trap",  32'(bus.trap),        32'd0);
    chk("q4_after_kmode", 32'(bus.kernel_mode), 32'd1);
    chk("q4_after_count", 32'(bus.instr_count), 32'd0);
    chk("q4_after_pid",   32'(bus.cur_pid),     32'd3);
    chk("q4_cause_hold",  32'(bus.trap_cause),  32'd1);

    // Quantum 2: branches and JR in drain do not trap, ADDI does
    dispatch(6'd5, 1'b1, 16'd2);
    retire(6'h00);
    retire(6'h00);
    chk("q2_count", 32'(bus.instr_count), 32'd2);
    retire(6'h0A);
    chk("q2_beq_notrap", 32'(bus.trap), 32'd0);
    retire(6'h13);
    chk("q2_jr_notrap",  32'(bus.trap), 32'd0);
    chk("q2_jr_user",    32'(bus.kernel_mode), 32'd0);
    exp_q.push_back(2'b01);
    retire(6'h02);
    chk("q2_addi_trap",  32'(bus.trap),       32'd1);
    chk("q2_addi_cause", 32'(bus.trap_cause), 32'd1);
    tick();

    // KERNEL_SWAP beats expiry on the same retire
    dispatch(6'd7);
    retire(6'h00);
    chk("ks_count1", 32'(bus.instr_count), 32'd1);
    exp_q.push_back(2'b10);
    retire(6'h21);
    chk("ks_trap",  32'(bus.trap),       32'd1);
    chk("ks_cause", 32'(bus.trap_cause), 32'd2);
    tick();
    chk("ks_kmode", 32'(bus.kernel_mode), 32'd1);

    // HALT
    dispatch(6'd9);
    exp_q.push_back(2'b11);
    retire(6'h19);
    chk("halt_trap",  32'(bus.trap),       32'd1);
    chk("halt_cause", 32'(bus.trap_cause), 32'd3);
    tick();
    chk("halt_pid_kept", 32'(bus.cur_pid), 32'd9);

    // IN with same-cycle ack: ack ignored, retires frozen while stalled
    dispatch(6'd4);
    retire(6'h08, 1'b1);
    chk("in_stall",  32'(bus.stall),       32'd1);
    chk("in_count",  32'(bus.instr_count), 32'd1);
    for (int i = 0; i < 3; i++) begin
      retire(6'h00);
      chk($sformatf("in_frozen_%0d", i), 32'(bus.instr_count), 32'd1);
      chk($sformatf("in_stall_%0d", i),  32'(bus.stall),       32'd1);
    end
    tick();
    bus.io_ack = 1'b1;
    chk("in_stall_pre_ack", 32'(bus.stall), 32'd1);
    tick();
    bus.io_ack = 1'b0;
    chk("in_stall_cleared", 32'(bus.stall), 32'd0);
    retire(6'h00);
    chk("in_count_resume", 32'(bus.instr_count), 32'd2);
    retire(6'h08);
    chk("drain_in_stall", 32'(bus.stall), 32'd1);
    chk("drain_in_notrap", 32'(bus.trap), 32'd0);

    // Asynchronous reset in DRAIN with io_wait set
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_kmode", 32'(bus.kernel_mode), 32'd1);
    chk("arst_stall", 32'(bus.stall),       32'd0);
    chk("arst_pid",   32'(bus.cur_pid),     32'd0);
    chk("arst_count", 32'(bus.instr_count), 32'd0);
    chk("arst_cause", 32'(bus.trap_cause),  32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // quantum_wr=0 stored as 1
    dispatch(6'd2, 1'b1, 16'd0);
    retire(6'h00);
    chk("q0_count", 32'(bus.instr_count), 32'd1);
    exp_q.push_back(2'b01);
    retire(6'h00);
    chk("q0_trap", 32'(bus.trap), 32'd1);
    tick();

    // Default quantum of 100 after reset
    do_reset();
    dispatch(6'd6);
    repeat (99) retire(6'h00);
    chk("qdef_count99", 32'(bus.instr_count), 32'd99);
    retire(6'h00);
    chk("qdef_count100", 32'(bus.instr_count), 32'd100);
    retire(6'h05);
    chk("qdef_drain_hold", 32'(bus.instr_count), 32'd100);
    chk("qdef_br_notrap",  32'(bus.trap),        32'd0);
    exp_q.push_back(2'b01);
    retire(6'h00);
    chk("qdef_trap",  32'(bus.trap),       32'd1);
    chk("qdef_cause", 32'(bus.trap_cause), 32'd1);
    tick();
    tick();

    chk("sb_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/quantum_scheduler.md
Name: quantum_scheduler

Overview:
- Round-robin preemption controller for the OS-capable CPU.
- Tracks kernel vs. user mode and the current PID, and counts retired user instructions against a programmable quantum.
- Raises a one-cycle trap on quantum expiry, KERNEL_SWAP or HALT; the PC logic uses it to vector into the kernel.
- Manages the IN-instruction input wait: stalls the core until the operator acknowledges.

Parameters:
- QUANTUM_W, 16, width of quantum register and instruction counter.
- DEFAULT_QUANTUM, 100, quantum loaded at reset.
- PID_W, 6, width of process identifier.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- instr_valid  in  1  one instruction retires this cycle.
- opcode  in  6  opcode of the retiring instruction.
- pid_wr  in  1  SET_PID strobe from the control unit.
- pid_in  in  PID_W  PID value accompanying pid_wr.
- quantum_wr  in  1  load new quantum.
- quantum_in  in  QUANTUM_W  new quantum value.
- io_ack  in  1  operator input confirm (single-cycle pulse, synchronised upstream).
- stall  out  1  freeze PC/pipeline.
- trap  out  1  one-cycle pulse: redirect PC to kernel vector.
- trap_cause  out  2  00 none, 01 quantum, 10 syscall, 11 exit.
- kernel_mode  out  1  1 when the kernel is executing.
- cur_pid  out  PID_W  currently scheduled PID.
- instr_count  out  QUANTUM_W  user instructions retired in the current quantum.

Behaviour:
- Reset (async, rst_n=0):
  - state=KERNEL, kernel_mode=1.
  - stall=0, trap=0, trap_cause=00.
  - cur_pid=0, instr_count=0, quantum=DEFAULT_QUANTUM.
  - pending_pid=0, io_wait=0.
  - Reset mid-operation aborts everything and returns to KERNEL.
- Opcodes: IN=0x08, JR=0x13, HALT=0x19, SET_PID=0x1C, KERNEL_SWAP=0x21.
- The retire qualifier "retire" = instr_valid & ~stall. Retires while stall=1 are ignored.
- States: KERNEL, USER, DRAIN, TRAP.
- KERNEL:
  - instr_count held at 0; kernel_mode=1.
  - quantum_wr loads quantum_in; a value of 0 is stored as 1.
  - pid_wr with pid_in!=0 latches pending_pid and sets an armed flag.
  - A retiring JR while armed → next cycle USER, cur_pid=pending_pid, armed cleared, kernel_mode=0.
  - A JR while not armed stays in KERNEL.
- USER:
  - Each retire increments instr_count.
  - pid_wr and quantum_wr are ignored.
  - Retiring KERNEL_SWAP → TRAP with cause 10.
  - Retiring HALT → TRAP with cause 11.
  - Otherwise, if the increment makes instr_count==quantum → DRAIN.
  - KERNEL_SWAP/HALT take priority over expiry on the same retire.
- DRAIN:
  - Counting stops.
  - The next retire of a non-branch, non-IN opcode (not 0x05, 0x0A, 0x0B, 0x13, 0x08) → TRAP with cause 01.
  - KERNEL_SWAP/HALT in DRAIN give causes 10/11.
  - Branches and IN retire normally and keep the block in DRAIN.
- TRAP:
  - trap=1 for exactly this cycle; trap_cause is updated on entry.
  - trap_cause holds until the next trap or reset.
  - Next cycle → KERNEL, instr_count=0, kernel_mode=1. cur_pid is retained; the kernel reads it.
- IO wait (orthogonal to the state machine, any state):
  - A retiring IN sets io_wait the next cycle; stall=io_wait.
  - io_ack while io_wait=1 clears io_wait the next cycle.
  - io_ack while io_wait=0 is ignored, including io_ack in the same cycle as the IN retire.
  - While stalled, instr_count and state are frozen and no trap issues.
- Latency: retire → state change and registered outputs appear one cycle later. All outputs are registered.
- instr_count never wraps: quantum ≤ 2^QUANTUM_W−1 and counting stops in DRAIN.

Decomposition:
- Package os_ctrl_pkg holds:
  - opcode localparams (IN, JR, HALT, SET_PID, KERNEL_SWAP, branch codes);
  - state enum {KERNEL, USER, DRAIN, TRAP};
  - cause enum {NONE, QUANTUM, SYSCALL, EXIT}.
- One sub-module, quantum_counter: a loadable, clearable, enabled counter with compare-equal output against quantum.

Test Plan:
- Reset, then SET_PID pid_in=3, then JR → kernel_mode=0 and cur_pid=3 one cycle after the JR retire; a JR without a prior SET_PID stays in KERNEL.
- quantum_wr=4 in KERNEL, dispatch, retire 4 ALU ops (0x00) → DRAIN; 5th op 0x00 → trap=1 for 1 cycle, cause=01, then kernel_mode=1, instr_count=0.
- quantum=2; after 2 retires, feed BEQ 0x0A then JR 0x13 then ADDI 0x02 → trap only on the ADDI retire, cause=01.
- USER with instr_count=1 and quantum=2, retire KERNEL_SWAP 0x21 → cause=10 (priority over expiry); separately retire HALT 0x19 → cause=11.
- Retire IN 0x08 with io_ack in the same cycle → stall=1 stays; instr_valid pulses ignored and instr_count frozen; io_ack 5 cycles later → stall=0 next cycle.
- Assert rst_n=0 in DRAIN with io_wait=1 → immediate kernel_mode=1, stall=0, cur_pid=0, quantum=100; quantum_wr=0 in KERNEL → stored quantum=1.
